// File: rtl/sized_data_memory.sv
// Byte-addressed LEGv8 data memory with sized, lane-aligned loads and stores.
// After every reset an init sequencer rewrites the index pattern (entry i = i),
// one entry per cycle, and requests are only accepted once it has finished.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | sequencer writing mem[init_cnt] = init_cnt, busy=1, requests ignored
// READY | init done, one load/store request accepted per cycle
module sized_data_memory #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          read_data_flag,
  input  logic                                          write_data_flag,
  input  logic [1:0]                                    access_size,
  input  logic                                          sign_extend,
  input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]    address_of_data,
  input  logic [DATA_WIDTH-1:0]                         data_to_write,
  output logic [DATA_WIDTH-1:0]                         data_read_out,
  output logic                                          read_valid,
  output logic                                          access_error,
  output logic                                          busy
);

  localparam int BO    = $clog2(DATA_WIDTH/8);
  localparam int NB    = DATA_WIDTH/8;
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] data_read_out_q, data_read_out_d;
  logic                  read_valid_q, read_valid_d;
  logic                  access_error_q, access_error_d;

  logic [ADDR_WIDTH-1:0] entry;
  logic [BO-1:0]         lane;
  logic [3:0]            acc_bytes;
  int                    nbits;
  int                    msb_idx;
  logic                  legal;
  logic                  req;

  logic [DATA_WIDTH-1:0] rd_entry;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic                  rd_msb;
  logic [DATA_WIDTH-1:0] wr_shift;
  logic [DATA_WIDTH-1:0] wr_merge;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Address split and alignment: the lane must be a multiple of the access
  // size, and the access may not be wider than one entry.
  assign entry     = address_of_data[ADDR_WIDTH+BO-1:BO];
  assign lane      = address_of_data[BO-1:0];
  assign acc_bytes = 4'd1 << access_size;
  assign nbits     = 8 << access_size;
  assign msb_idx   = (nbits > DATA_WIDTH) ? DATA_WIDTH - 1 : nbits - 1;
  assign legal     = (int'(access_size) <= BO) &&
                     ((int'(lane) & (int'(acc_bytes) - 1)) == 0);
  assign req       = (state_q == READY) && (read_data_flag || write_data_flag);

  // Load path: pick the entry, shift the addressed lane down to bit 0.
  assign rd_entry = mem_q[entry];
  assign rd_shift = rd_entry >> {lane, 3'b000};
  assign wr_shift = data_to_write << {lane, 3'b000};

  // Extend the extracted field; doubles are never sign-extended.
  always_comb begin
    rd_msb = 1'b0;
    rd_ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i == msb_idx) rd_msb = rd_shift[i];
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < nbits) rd_ext[i] = rd_shift[i];
      else           rd_ext[i] = sign_extend && (access_size != 2'd3) && rd_msb;
    end
  end

  // Store path: replace only the addressed lanes, keep the rest of the entry.
  always_comb begin
    wr_merge = rd_entry;
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(lane) && b < int'(lane) + int'(acc_bytes))
        wr_merge[8*b +: 8] = wr_shift[8*b +: 8];
    end
  end

  // Single write port shared by the init sequencer and legal stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = entry;
    mem_wdata = wr_merge;
    if (!reset) begin
      if (state_q == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt_q;
        mem_wdata = DATA_WIDTH'(init_cnt_q);
      end else if (write_data_flag && legal) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array; reads are taken from the pre-edge contents (read-first).
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Init FSM next state: walk every entry once, then stay READY.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) state_d = READY;
    end
  end

  // Response next state: errors and load results appear one cycle later.
  always_comb begin
    data_read_out_d = data_read_out_q;
    read_valid_d    = 1'b0;
    access_error_d  = 1'b0;
    if (req) begin
      if (!legal) begin
        access_error_d = 1'b1;
        if (read_data_flag) begin
          read_valid_d    = 1'b1;
          data_read_out_d = '0;
        end
      end else if (read_data_flag) begin
        read_valid_d    = 1'b1;
        data_read_out_d = rd_ext;
      end
    end
  end

  // Control and response registers; reset restarts init and drops results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= INIT;
      init_cnt_q      <= '0;
      data_read_out_q <= '0;
      read_valid_q    <= 1'b0;
      access_error_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      data_read_out_q <= data_read_out_d;
      read_valid_q    <= read_valid_d;
      access_error_q  <= access_error_d;
    end
  end

  assign data_read_out = data_read_out_q;
  assign read_valid    = read_valid_q;
  assign access_error  = access_error_q;
  assign busy          = reset || (state_q == INIT);

endmodule

// File: tb/tb_sized_data_memory.sv
// Directed bench for sized_data_memory: 64/8 default instance and a 32/4 instance.
module tb_sized_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit, 256-entry instance
  logic        a_reset = 1'b1;
  logic        a_rd = 1'b0, a_wr = 1'b0, a_sext = 1'b0;
  logic [1:0]  a_size = 2'd0;
  logic [10:0] a_addr = '0;
  logic [63:0] a_wdata = '0;
  logic [63:0] a_dout;
  logic        a_valid, a_err, a_busy;

  // 32-bit, 16-entry instance
  logic        b_reset = 1'b1;
  logic        b_rd = 1'b0, b_wr = 1'b0, b_sext = 1'b0;
  logic [1:0]  b_size = 2'd0;
  logic [5:0]  b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [31:0] b_dout;
  logic        b_valid, b_err, b_busy;

  sized_data_memory #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) u_a (
    .clk(clk), .reset(a_reset), .read_data_flag(a_rd), .write_data_flag(a_wr),
    .access_size(a_size), .sign_extend(a_sext), .address_of_data(a_addr),
    .data_to_write(a_wdata), .data_read_out(a_dout), .read_valid(a_valid),
    .access_error(a_err), .busy(a_busy)
  );

  sized_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_b (
    .clk(clk), .reset(b_reset), .read_data_flag(b_rd), .write_data_flag(b_wr),
    .access_size(b_size), .sign_extend(b_sext), .address_of_data(b_addr),
    .data_to_write(b_wdata), .data_read_out(b_dout), .read_valid(b_valid),
    .access_error(b_err), .busy(b_busy)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [10:0] addr;
    logic [63:0] wdata;
    logic        ev;
    logic        ee;
    logic [63:0] ed;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] size, logic sext,
                              logic [10:0] addr, logic [63:0] wdata,
                              logic ev, logic ee, logic [63:0] ed);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sext = sext; v.addr = addr;
    v.wdata = wdata; v.ev = ev; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Counts cycles with busy=1 starting now (caller is at a negedge just after
  // releasing reset) and notes any response pulse seen while busy.
  task automatic count_busy_a(output int n, output logic pulsed);
    n = 0;
    pulsed = 1'b0;
    #1;
    while (a_busy && n < 2000) begin
      n++;
      if (a_valid || a_err) pulsed = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    #1;
    while (b_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_a(input string tag, input vec_t v);
    a_rd = v.rd; a_wr = v.wr; a_size = v.size; a_sext = v.sext;
    a_addr = v.addr; a_wdata = v.wdata;
    @(negedge clk);
    check({tag, " valid"}, 64'(a_valid), 64'(v.ev));
    check({tag, " error"}, 64'(a_err), 64'(v.ee));
    check({tag, " data"}, a_dout, v.ed);
  endtask

  task automatic run_b(input string tag, input vec_t v);
    b_rd = v.rd; b_wr = v.wr; b_size = v.size; b_sext = v.sext;
    b_addr = v.addr[5:0]; b_wdata = v.wdata[31:0];
    @(negedge clk);
    check({tag, " valid"}, 64'(b_valid), 64'(v.ev));
    check({tag, " error"}, 64'(b_err), 64'(v.ee));
    check({tag, " data"}, 64'(b_dout), 64'(v.ed[31:0]));
  endtask

  task automatic idle_a();
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  int   n_busy;
  logic pulsed;

  initial begin
    //          rd wr sz sx addr     wdata                     ev ee expected data
    va.push_back(mk(1,0,3,0,11'h038, 64'h0,                    1,0,64'h7));
    va.push_back(mk(1,0,3,0,11'h028, 64'h0,                    1,0,64'h5));
    va.push_back(mk(0,1,0,0,11'h029, 64'hFF,                   0,0,64'h5));
    va.push_back(mk(1,0,3,0,11'h028, 64'h0,                    1,0,64'hFF05));
    va.push_back(mk(1,0,0,1,11'h029, 64'h0,                    1,0,64'hFFFF_FFFF_FFFF_FFFF));
    va.push_back(mk(1,0,0,0,11'h029, 64'h0,                    1,0,64'hFF));
    va.push_back(mk(0,1,1,0,11'h02B, 64'h1234,                 0,1,64'hFF));
    va.push_back(mk(1,0,3,0,11'h028, 64'h0,                    1,0,64'hFF05));
    va.push_back(mk(1,0,2,0,11'h02A, 64'h0,                    1,1,64'h0));
    va.push_back(mk(1,1,3,0,11'h030, 64'hDEAD_BEEF_0000_0001,  1,0,64'h6));
    va.push_back(mk(1,0,3,0,11'h030, 64'h0,                    1,0,64'hDEAD_BEEF_0000_0001));
    va.push_back(mk(1,0,2,1,11'h034, 64'h0,                    1,0,64'hFFFF_FFFF_DEAD_BEEF));
    va.push_back(mk(1,0,1,0,11'h036, 64'h0,                    1,0,64'hDEAD));
    va.push_back(mk(0,0,0,0,11'h000, 64'h0,                    0,0,64'hDEAD));
    va.push_back(mk(0,1,2,0,11'h03C, 64'h8000_0000_1122_3344,  0,0,64'hDEAD));
    va.push_back(mk(1,0,3,0,11'h038, 64'h0,                    1,0,64'h1122_3344_0000_0007));
    va.push_back(mk(1,0,3,1,11'h038, 64'h0,                    1,0,64'h1122_3344_0000_0007));
    va.push_back(mk(1,0,1,1,11'h03E, 64'h0,                    1,0,64'h1122));
    va.push_back(mk(1,0,0,1,11'h03F, 64'h0,                    1,0,64'h11));
    va.push_back(mk(1,0,0,1,11'h035, 64'h0,                    1,0,64'hFFFF_FFFF_FFFF_FFBE));
    va.push_back(mk(1,0,1,0,11'h039, 64'h0,                    1,1,64'h0));
    va.push_back(mk(1,0,3,0,11'h03C, 64'h0,                    1,1,64'h0));
    va.push_back(mk(1,0,3,0,11'h7F8, 64'h0,                    1,0,64'hFF));

    vb.push_back(mk(1,0,3,0,11'h00,  64'h0,                    1,1,64'h0));
    vb.push_back(mk(0,1,1,0,11'h3E,  64'h8001,                 0,0,64'h0));
    vb.push_back(mk(1,0,1,1,11'h3E,  64'h0,                    1,0,64'hFFFF_8001));
    vb.push_back(mk(1,0,1,0,11'h3E,  64'h0,                    1,0,64'h8001));
    vb.push_back(mk(1,0,2,0,11'h3C,  64'h0,                    1,0,64'h8001_000F));
    vb.push_back(mk(0,1,3,0,11'h00,  64'h0,                    0,1,64'h8001_000F));
    vb.push_back(mk(1,0,2,0,11'h00,  64'h0,                    1,0,64'h0));
    vb.push_back(mk(1,0,2,0,11'h04,  64'h0,                    1,0,64'h1));
    vb.push_back(mk(1,0,0,1,11'h3F,  64'h0,                    1,0,64'hFFFF_FF80));

    // Reset state
    repeat (3) @(negedge clk);
    check("A reset busy",  64'(a_busy),  64'd1);
    check("A reset valid", 64'(a_valid), 64'd0);
    check("A reset error", 64'(a_err),   64'd0);
    check("A reset data",  a_dout,       64'd0);

    // Release reset with a store+load hammering entry 7 the whole time busy.
    a_reset = 1'b0;
    a_rd = 1'b1; a_wr = 1'b1; a_size = 2'd3; a_addr = 11'h038;
    a_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    count_busy_a(n_busy, pulsed);
    idle_a();
    check("A busy cycles", 64'(n_busy), 64'd256);
    check("A pulses while busy", 64'(pulsed), 64'd0);
    check("A valid at ready", 64'(a_valid), 64'd0);

    for (int i = 0; i < va.size(); i++) run_a($sformatf("A%0d", i), va[i]);
    idle_a();

    // Reset partway through init restarts the full sequence.
    @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    check("A reset2 data", a_dout, 64'd0);
    a_reset = 1'b0;
    repeat (100) @(negedge clk);
    check("A busy mid-init", 64'(a_busy), 64'd1);
    a_reset = 1'b1;
    @(negedge clk);
    check("A reset3 busy", 64'(a_busy), 64'd1);
    a_reset = 1'b0;
    count_busy_a(n_busy, pulsed);
    check("A busy after mid-init reset", 64'(n_busy), 64'd256);
    run_a("A entry7 restored", mk(1,0,3,0,11'h038, 64'h0, 1,0,64'h7));
    run_a("A entry5 restored", mk(1,0,3,0,11'h028, 64'h0, 1,0,64'h5));
    idle_a();

    // 32-bit, 16-entry instance
    @(negedge clk);
    check("B reset busy", 64'(b_busy), 64'd1);
    check("B reset data", 64'(b_dout), 64'd0);
    b_reset = 1'b0;
    count_busy_b(n_busy);
    check("B busy cycles", 64'(n_busy), 64'd16);
    for (int i = 0; i < vb.size(); i++) run_b($sformatf("B%0d", i), vb[i]);
    b_rd = 1'b0; b_wr = 1'b0;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
